// File: rtl/ps2_led_ctrl_if.sv
// Byte-level link between ps2_led_ctrl (master) and the ps2_transmit / PS/2 receive path (slave).
// w_enable is a 1-cycle strobe issued only while tx_idle=1, data_out is valid with it and held
// until the next strobe; tx_finished and rx_done_tick are 1-cycle pulses with no back-pressure.
interface ps2_led_ctrl_if;
    logic       w_enable;
    logic [7:0] data_out;
    logic       tx_finished;
    logic       tx_idle;
    logic       rx_done_tick;
    logic [7:0] rx_data;

    modport master (
        output w_enable, data_out,
        input  tx_finished, tx_idle, rx_done_tick, rx_data
    );

    modport slave (
        input  w_enable, data_out,
        output tx_finished, tx_idle, rx_done_tick, rx_data
    );
endinterface

// File: rtl/ps2_led_ctrl.sv
// PS/2 "Set LEDs" sequencer: sends 0xED then the LED byte, each ACKed with 0xFA, with resend/timeout retry.
// Optional macro PS2_RESET_CMD_EN prepends a 0xFF reset command and BAT (0xAA) wait after reset.
module ps2_led_ctrl #(
    parameter int ACK_TIMEOUT = 2_000_000,
    parameter int MAX_RETRY   = 3,
    parameter int BAT_TIMEOUT = 50_000_000
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           led_req,
    input  logic [2:0]     led_val,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [3:0]     state_dbg,
    ps2_led_ctrl_if.master ps2
);
    localparam int TMAX = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        IDLE          = 4'd0,
        CMD_TX        = 4'd1,
        CMD_WAIT_TX   = 4'd2,
        CMD_WAIT_ACK  = 4'd3,
        LED_TX        = 4'd4,
        LED_WAIT_TX   = 4'd5,
        LED_WAIT_ACK  = 4'd6
`ifdef PS2_RESET_CMD_EN
        ,
        INIT_TX       = 4'd7,
        INIT_WAIT_TX  = 4'd8,
        INIT_WAIT_ACK = 4'd9,
        INIT_WAIT_BAT = 4'd10
`endif
    } state_t;

`ifdef PS2_RESET_CMD_EN
    localparam state_t RESET_STATE = INIT_TX;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t        state, state_n;
    logic [TW-1:0] timer;
    logic [RW-1:0] retry, retry_inc;
    logic          pending;
    logic [2:0]    pend_val, cur_val;
    logic          w_enable_q, w_enable_n;
    logic [7:0]    data_q, data_n;
    logic          done_q, done_n, err_q, err_n;
    logic          start, fire, acked, nacked, give_up;
    logic          rx_ack, rx_resend, ack_expired, retry_full;

    assign rx_ack      = ps2.rx_done_tick && (ps2.rx_data == 8'hFA);
    assign rx_resend   = ps2.rx_done_tick && (ps2.rx_data == 8'hFE);
    assign ack_expired = (timer == TW'(ACK_TIMEOUT - 1));
    assign retry_inc   = retry + RW'(1);
    assign retry_full  = (retry_inc > RW'(MAX_RETRY));

`ifdef PS2_RESET_CMD_EN
    logic rx_bat_ok, rx_bat_fail, bat_expired;
    assign rx_bat_ok   = ps2.rx_done_tick && (ps2.rx_data == 8'hAA);
    assign rx_bat_fail = ps2.rx_done_tick && (ps2.rx_data == 8'hFC);
    assign bat_expired = (timer == TW'(BAT_TIMEOUT - 1));
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= RESET_STATE;
            timer      <= '0;
            retry      <= '0;
            pending    <= 1'b0;
            pend_val   <= 3'b000;
            cur_val    <= 3'b000;
            w_enable_q <= 1'b0;
            data_q     <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            w_enable_q <= w_enable_n;
            data_q     <= data_n;
            done_q     <= done_n;
            err_q      <= err_n;
            // Timer restarts on every state change, so it reads 0 on entry to each wait state.
            if (state_n != state)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + TW'(1);
            if (start || acked)
                retry <= '0;
            else if (nacked)
                retry <= retry_inc;
            if (start) begin
                pending <= 1'b0;
                cur_val <= led_req ? led_val : pend_val;
            end else if (led_req) begin
                pending  <= 1'b1;
                pend_val <= led_val;
            end
        end
    end

    always_comb begin
        state_n = state;
        start   = 1'b0;
        fire    = 1'b0;
        acked   = 1'b0;
        nacked  = 1'b0;
        give_up = 1'b0;
        case (state)
            IDLE: if (led_req || pending) begin
                start   = 1'b1;
                state_n = CMD_TX;
            end
            CMD_TX: if (ps2.tx_idle) begin
                fire    = 1'b1;
                state_n = CMD_WAIT_TX;
            end
            CMD_WAIT_TX: if (ps2.tx_finished) state_n = CMD_WAIT_ACK;
            CMD_WAIT_ACK: begin
                if (rx_ack) begin
                    acked   = 1'b1;
                    state_n = LED_TX;
                end else if (rx_resend || ack_expired) begin
                    nacked  = 1'b1;
                    give_up = retry_full;
                    state_n = retry_full ? IDLE : CMD_TX;
                end
            end
            LED_TX: if (ps2.tx_idle) begin
                fire    = 1'b1;
                state_n = LED_WAIT_TX;
            end
            LED_WAIT_TX: if (ps2.tx_finished) state_n = LED_WAIT_ACK;
            LED_WAIT_ACK: begin
                if (rx_ack) begin
                    acked   = 1'b1;
                    state_n = IDLE;
                end else if (rx_resend || ack_expired) begin
                    nacked  = 1'b1;
                    give_up = retry_full;
                    state_n = retry_full ? IDLE : LED_TX;
                end
            end
`ifdef PS2_RESET_CMD_EN
            INIT_TX: if (ps2.tx_idle) begin
                fire    = 1'b1;
                state_n = INIT_WAIT_TX;
            end
            INIT_WAIT_TX: if (ps2.tx_finished) state_n = INIT_WAIT_ACK;
            INIT_WAIT_ACK: begin
                if (rx_ack) begin
                    acked   = 1'b1;
                    state_n = INIT_WAIT_BAT;
                end else if (rx_resend || ack_expired) begin
                    nacked  = 1'b1;
                    give_up = retry_full;
                    state_n = retry_full ? IDLE : INIT_TX;
                end
            end
            INIT_WAIT_BAT: begin
                if (rx_bat_ok) begin
                    state_n = IDLE;
                end else if (rx_bat_fail || bat_expired) begin
                    give_up = 1'b1;
                    state_n = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        w_enable_n = fire;
        data_n     = data_q;
        if (fire) begin
            case (state)
                CMD_TX:  data_n = 8'hED;
                LED_TX:  data_n = {5'b00000, cur_val};
                default: data_n = 8'hFF;
            endcase
        end
        done_n = acked && (state == LED_WAIT_ACK);
        err_n  = give_up;
        busy   = !((state == IDLE) && !pending);
    end

    assign ps2.w_enable = w_enable_q;
    assign ps2.data_out = data_q;
    assign done         = done_q;
    assign err          = err_q;
    assign state_dbg    = state;
endmodule

// File: tb/tb_ps2_led_ctrl.sv
// Bench for ps2_led_ctrl: plays ps2_transmit and the keyboard, predicts strobed bytes and done/err outcomes.
module tb_ps2_led_ctrl;
    localparam int ACK_TO    = 100;
    localparam int MAX_RETRY = 3;
    localparam int BAT_TO    = 300;
    localparam int R_ACK = 0, R_FE = 1, R_TO = 2, R_EDGE = 3;
`ifdef PS2_RESET_CMD_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       led_req;
    logic [2:0] led_val;
    logic       busy, done, err;
    logic [3:0] state_dbg;
    ps2_led_ctrl_if ps2();

    ps2_led_ctrl #(.ACK_TIMEOUT(ACK_TO), .MAX_RETRY(MAX_RETRY), .BAT_TIMEOUT(BAT_TO)) dut (
        .clk(clk), .reset(reset), .led_req(led_req), .led_val(led_val),
        .busy(busy), .done(done), .err(err), .state_dbg(state_dbg), .ps2(ps2)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0;
    int done_cnt = 0, err_cnt = 0, strobe_cnt = 0;
    int base_done, base_err, base_strobe;
    logic [7:0] exp_q[$];
    int         resp_q[$];

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (ps2.w_enable) strobe_cnt++;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: each byte is sent once plus once per failed reply, up to MAX_RETRY resends.
    task automatic plan_byte(input logic [7:0] b, input int nf, input int kind, output bit acked);
        int sends;
        sends = (nf > MAX_RETRY) ? MAX_RETRY + 1 : nf + 1;
        for (int i = 0; i < sends; i++) begin
            exp_q.push_back(b);
            if (i < nf) resp_q.push_back((kind == 0) ? int'($urandom_range(R_FE, R_TO)) : kind);
            else resp_q.push_back(R_ACK);
        end
        acked = (nf <= MAX_RETRY);
    endtask

    task automatic plan_txn(input logic [2:0] v, input int nf_cmd, input int nf_led, input int kind,
                            output int exp_done, output int exp_err);
        bit a;
        plan_byte(8'hED, nf_cmd, kind, a);
        if (!a) begin
            exp_done = 0;
            exp_err  = 1;
            return;
        end
        plan_byte({5'b00000, v}, nf_led, kind, a);
        exp_done = a ? 1 : 0;
        exp_err  = a ? 0 : 1;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        ps2.rx_done_tick = 1'b1;
        ps2.rx_data      = b;
        @(negedge clk);
        ps2.rx_done_tick = 1'b0;
    endtask

    task automatic wait_strobe(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ps2.w_enable) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_txn(input logic [2:0] v);
        base_done   = done_cnt;
        base_err    = err_cnt;
        base_strobe = strobe_cnt;
        @(negedge clk);
        led_req = 1'b1;
        led_val = v;
        @(negedge clk);
        led_req = 1'b0;
        check_eq("busy_after_req", busy, 1);
    endtask

    task automatic run_byte(input int resp, input bit inject, input logic [2:0] v_inj);
        bit ok, quiet;
        logic [7:0] exp_b;
        int d;
        exp_b = exp_q.pop_front();
        wait_strobe(ok);
        check_eq("strobe_seen", ok, 1);
        if (!ok) return;
        check_eq("data_out", ps2.data_out, exp_b);
        @(negedge clk);
        check_eq("we_width", ps2.w_enable, 0);
        check_eq("data_hold", ps2.data_out, exp_b);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        ps2.tx_finished = 1'b1;
        if (resp == R_TO) d = ACK_TO - 1;
        else if (resp == R_EDGE) d = ACK_TO;
        else d = $urandom_range(4, 60);
        quiet = 1'b1;
        for (int k = 1; k <= d; k++) begin
            @(negedge clk);
            if (ps2.w_enable || err) quiet = 1'b0;
            if (k == 1) begin
                ps2.tx_finished  = 1'b0;
                ps2.rx_done_tick = 1'($urandom_range(0, 1));
                ps2.rx_data      = 8'h1C;
            end
            if (k == 2) begin
                ps2.rx_done_tick = 1'b0;
                if (inject) begin
                    led_req = 1'b1;
                    led_val = 3'($urandom_range(0, 7));
                end
            end
            if (k == 3 && inject) led_val = v_inj;
            if (k == 4) led_req = 1'b0;
            if (k == d && resp != R_TO) begin
                ps2.rx_done_tick = 1'b1;
                ps2.rx_data      = (resp == R_FE) ? 8'hFE : 8'hFA;
            end
        end
        if (resp != R_TO) begin
            @(negedge clk);
            ps2.rx_done_tick = 1'b0;
        end
        check_eq("no_early_event", quiet, 1);
    endtask

    task automatic run_scenario(input bit inject, input logic [2:0] v_inj, input int exp_done, input int exp_err);
        int n;
        bit first;
        n = exp_q.size();
        first = 1'b1;
        while (exp_q.size() > 0) begin
            run_byte(resp_q.pop_front(), first && inject, v_inj);
            first = 1'b0;
        end
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check_eq("busy_fall", busy, 0);
        repeat (2) @(negedge clk);
        check_eq("done_count", done_cnt - base_done, exp_done);
        check_eq("err_count", err_cnt - base_err, exp_err);
        check_eq("strobe_count", strobe_cnt - base_strobe, n);
    endtask

    task automatic do_init(input bit bat_fail);
`ifdef PS2_RESET_CMD_EN
        bit ok;
        base_done = done_cnt;
        base_err  = err_cnt;
        wait_strobe(ok);
        check_eq("init_strobe", ok, 1);
        check_eq("init_byte", ps2.data_out, 8'hFF);
        @(negedge clk);
        ps2.tx_finished = 1'b1;
        @(negedge clk);
        ps2.tx_finished = 1'b0;
        repeat (5) @(negedge clk);
        rx_pulse(8'hFA);
        repeat (10) @(negedge clk);
        check_eq("init_busy", busy, 1);
        rx_pulse(bat_fail ? 8'hFC : 8'hAA);
        repeat (3) @(negedge clk);
        check_eq("init_busy_fall", busy, 0);
        check_eq("init_done", done_cnt - base_done, 0);
        check_eq("init_err", err_cnt - base_err, bat_fail ? 1 : 0);
`else
        if (bat_fail) @(negedge clk);
`endif
    endtask

    initial begin
        int ed, ee, ed2, ee2;
        bit quiet;
        logic [2:0] v, v2;
        reset = 1'b0;
        led_req = 1'b0;
        led_val = 3'b000;
        ps2.tx_finished = 1'b0;
        ps2.tx_idle = 1'b1;
        ps2.rx_done_tick = 1'b0;
        ps2.rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_w_enable", ps2.w_enable, 0);
        check_eq("rst_data_out", ps2.data_out, 8'h00);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_busy", busy, INIT_EN);
        reset = 1'b1;
        do_init(1'b0);

        // Stray tx_finished / rx bytes while idle must not start anything.
        base_strobe = strobe_cnt;
        quiet = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) quiet = 1'b0;
            ps2.tx_finished  = 1'($urandom_range(0, 1));
            ps2.rx_done_tick = 1'($urandom_range(0, 1));
            ps2.rx_data      = (i % 2 == 0) ? 8'hFA : 8'hFE;
        end
        @(negedge clk);
        ps2.tx_finished  = 1'b0;
        ps2.rx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("idle_stray_busy", quiet && !busy, 1);
        check_eq("idle_stray_strobe", strobe_cnt - base_strobe, 0);

        // Plain exchange, then two resends of 0xED, then retries exhausted by silence.
        plan_txn(3'b101, 0, 0, R_ACK, ed, ee);
        start_txn(3'b101);
        run_scenario(1'b0, 3'b000, ed, ee);
        plan_txn(3'b101, 2, 0, R_FE, ed, ee);
        start_txn(3'b101);
        run_scenario(1'b0, 3'b000, ed, ee);
        plan_txn(3'b011, 4, 0, R_TO, ed, ee);
        start_txn(3'b011);
        run_scenario(1'b0, 3'b000, ed, ee);

        // Requests while busy: latest value is queued and runs after the first sequence.
        plan_txn(3'b001, 0, 0, R_ACK, ed, ee);
        plan_txn(3'b110, 0, 0, R_ACK, ed2, ee2);
        start_txn(3'b001);
        run_scenario(1'b1, 3'b110, ed + ed2, ee + ee2);

        // Transmitter not ready: no strobe until tx_idle returns.
        ps2.tx_idle = 1'b0;
        plan_txn(3'b010, 0, 0, R_ACK, ed, ee);
        start_txn(3'b010);
        repeat (50) @(negedge clk);
        check_eq("tx_idle_hold", strobe_cnt - base_strobe, 0);
        ps2.tx_idle = 1'b1;
        run_scenario(1'b0, 3'b000, ed, ee);

        // ACK arriving in the very cycle the timeout expires wins.
        plan_txn(3'b111, 0, 0, R_ACK, ed, ee);
        resp_q[0] = R_EDGE;
        start_txn(3'b111);
        run_scenario(1'b0, 3'b000, ed, ee);

        for (int t = 0; t < 12; t++) begin
            int nc, nl;
            v  = 3'($urandom_range(0, 7));
            nc = ($urandom_range(0, 5) == 0) ? 4 : int'($urandom_range(0, 2));
            nl = ($urandom_range(0, 5) == 0) ? 4 : int'($urandom_range(0, 2));
            plan_txn(v, nc, nl, 0, ed, ee);
            start_txn(v);
            run_scenario(1'b0, 3'b000, ed, ee);
        end

        // Asynchronous reset while the 0xED strobe is high.
        v2 = 3'b100;
        start_txn(v2);
        begin
            bit ok;
            wait_strobe(ok);
            check_eq("areset_strobe", ok, 1);
            #2 reset = 1'b0;
            #1;
            check_eq("areset_w_enable", ps2.w_enable, 0);
            check_eq("areset_data_out", ps2.data_out, 8'h00);
            check_eq("areset_busy", busy, INIT_EN);
        end
        @(negedge clk);
        reset = 1'b1;
        do_init(1'b0);
        if (INIT_EN) begin
            reset = 1'b0;
            @(negedge clk);
            reset = 1'b1;
            do_init(1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
